// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/capture FSM for the 8-bit combinational ALU.
// Commands are queued on cmd_*, issued on registered alu_* ports, and returned on rsp_*.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_opcode,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [7:0]       alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [3:0]       rsp_opcode,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    PRESENT
  } state_t;

  state_t state_q, state_d;

  // FIFO storage: {a, b, opcode}
  logic [19:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          capture;
  logic          rsp_fire;
  logic          div_zero;
  logic [19:0]   head;

  logic [7:0]       alu_a_q, alu_b_q;
  logic [3:0]       alu_opcode_q;
  logic [7:0]       rsp_data_q;
  logic [3:0]       rsp_opcode_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] op_count_q;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign push       = cmd_valid & ~fifo_full;
  assign head       = mem_q[rd_ptr_q];
  assign rsp_fire   = rsp_valid & rsp_ready;
  assign div_zero   = (alu_opcode_q == OP_DIV) && (alu_b_q == 8'd0);

  // ---------------- FIFO ----------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_a, cmd_b, cmd_opcode};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Power-of-two depth lets the pointers wrap by natural overflow.
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        capture = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
    end else if (pop) begin
      alu_a_q      <= head[19:12];
      alu_b_q      <= head[11:4];
      alu_opcode_q <= head[3:0];
    end
  end

  // Divide-by-zero result is forced to all-ones regardless of what the ALU drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q   <= '0;
      rsp_opcode_q <= '0;
      rsp_err_q    <= 1'b0;
    end else if (capture) begin
      rsp_data_q   <= div_zero ? 8'hFF : alu_out;
      rsp_opcode_q <= alu_opcode_q;
      rsp_err_q    <= div_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (rsp_fire && (op_count_q != '1)) begin
      op_count_q <= op_count_q + 1'b1;
    end
  end

  assign cmd_ready  = ~fifo_full;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = (state_q == PRESENT);
  assign rsp_data   = rsp_data_q;
  assign rsp_opcode = rsp_opcode_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE) | ~fifo_empty;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized and directed bench for alu_cmd_sequencer with a behavioural ALU stub
// and an in-order response scoreboard.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a, cmd_b;
  logic [3:0]       cmd_opcode;
  logic [7:0]       alu_a, alu_b;
  logic [3:0]       alu_opcode;
  logic [7:0]       alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [3:0]       rsp_opcode;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int resp_cnt = 0;
  logic [12:0] exp_q[$];
  int fire_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_opcode(rsp_opcode), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  // ALU stub; divide by zero returns 0 so the sequencer's 8'hFF override is visible.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 8'd0) ? 8'h00 : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~a;
      4'd8:    return a + b;
      4'd9:    return a - 8'd1;
      4'd10:   return a << 1;
      4'd11:   return a >> 1;
      4'd12:   return ~(a & b);
      4'd13:   return a + 8'd1;
      4'd14:   return b - 8'd1;
      default: return b + 8'd1;
    endcase
  endfunction

  assign alu_out = alu_f(alu_a, alu_b, alu_opcode);

  // Expected response packed as {opcode, err, data}.
  function automatic logic [12:0] expect_rsp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic err;
    err = (op == 4'd3) && (b == 8'd0);
    return {op, err, err ? 8'hFF : alu_f(a, b, op)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: outputs reflect handshakes up to the previous rising edge;
  // handshakes seen here take effect on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      resp_cnt = 0;
    end else begin
      check("busy", busy, exp_q.size() != 0);
      check("op_count", op_count, resp_cnt);
      if (rsp_valid) check("rsp_spurious", exp_q.size() != 0, 1);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() != 0) check("rsp", {rsp_opcode, rsp_err, rsp_data}, exp_q.pop_front());
        if (resp_cnt != (1 << CNT_W) - 1) resp_cnt++;
        fire_cyc.push_back(cyc);
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(expect_rsp(cmd_a, cmd_b, cmd_opcode));
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        return;
      end
    end
    check("send_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int i = 0;
    while (!rsp_valid && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    check("wait_rsp", rsp_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0]  la[6], lb[6];
    logic [3:0]  lo[6];
    logic [12:0] first_exp;
    int acc;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_opcode = '0; rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    check("rst_rsp", {rsp_data, rsp_opcode, rsp_err}, 0);
    check("rst_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("rst_cmd_ready", cmd_ready, 1);

    // Add with latency check
    rsp_ready = 1'b1;
    cmd_a = 8'd200; cmd_b = 8'd100; cmd_opcode = 4'd0; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    check("t1_lat0", rsp_valid, 0);
    @(posedge clk); #1 check("t1_lat1", rsp_valid, 0);
    @(posedge clk); #1 check("t1_lat2", rsp_valid, 1);
    check("t1_data", rsp_data, 44);
    check("t1_err", rsp_err, 0);
    check("t1_opcode", rsp_opcode, 0);
    @(posedge clk); #1 check("t1_op_count", op_count, 1);
    check("t1_done", rsp_valid, 0);

    // Multiply then divide, two cycles apart
    fire_cyc.delete();
    send(8'd16, 8'd20, 4'd2);
    send(8'd100, 8'd7, 4'd3);
    drain();
    check("t2_fires", fire_cyc.size(), 2);
    if (fire_cyc.size() == 2) check("t2_gap", fire_cyc[1] - fire_cyc[0], 2);

    // Divide by zero, then b+1
    rsp_ready = 1'b0;
    send(8'd55, 8'd0, 4'd3);
    wait_rsp();
    check("t3_data", rsp_data, 8'hFF);
    check("t3_err", rsp_err, 1);
    rsp_ready = 1'b1;
    send(8'd9, 8'd1, 4'd15);
    wait_rsp();
    check("t3b_data", rsp_data, 2);
    check("t3b_err", rsp_err, 0);
    drain();

    // Backpressure: DEPTH+1 accepted, response held stable
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      la[i] = 8'($urandom); lb[i] = 8'($urandom_range(1, 255)); lo[i] = 4'($urandom_range(0, 2));
    end
    first_exp = expect_rsp(la[0], lb[0], lo[0]);
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = (acc < 6);
      cmd_a = la[acc % 6]; cmd_b = lb[acc % 6]; cmd_opcode = lo[acc % 6];
      @(negedge clk);
      if (cmd_valid && cmd_ready) acc++;
      @(posedge clk); #1;
      if (rsp_valid) check("t4_hold", rsp_data, first_exp[7:0]);
    end
    cmd_valid = 1'b0;
    check("t4_accepted", acc, DEPTH + 1);
    check("t4_cmd_ready", cmd_ready, 0);
    check("t4_rsp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    drain();
    check("t4_busy", busy, 0);

    // Reset mid-stream discards everything
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i + 3), 8'd5, 4'd0);
    wait_rsp();
    #3 rst_n = 1'b0;
    #1;
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_alu", {alu_a, alu_b, alu_opcode}, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_stale", rsp_valid, 0);
    check("t5_op_count", op_count, 0);

    // Back-to-back increments
    fire_cyc.delete();
    for (int i = 0; i < 8; i++) send(8'(i), 8'd1, 4'd8);
    drain();
    check("t6_fires", fire_cyc.size(), 8);
    for (int i = 1; i < fire_cyc.size(); i++) check("t6_gap", fire_cyc[i] - fire_cyc[i-1], 2);
    check("t6_op_count", op_count, 8);

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      cmd_valid  = 1'($urandom);
      cmd_a      = 8'($urandom);
      cmd_b      = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      cmd_opcode = ($urandom_range(0, 2) == 0) ? 4'd3 : 4'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("t7_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Sequential front-end that drives the team's 8-bit combinational ALU (operands a/b, 4-bit opcode, 8-bit out). It accepts commands through a valid/ready handshake into a small FIFO and issues them one at a time on registered ALU input ports. It captures the ALU result and returns it, with opcode echo and divide-by-zero error flag, on a valid/ready response channel. It sits between the control/datapath master and the ALU instance.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, minimum 2.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept; equals !fifo_full
cmd_a  input  8  operand a
cmd_b  input  8  operand b
cmd_opcode  input  4  ALU opcode (0000 add ... 1111 b+1)
alu_a  output  8  registered operand to ALU a
alu_b  output  8  registered operand to ALU b
alu_opcode  output  4  registered opcode to ALU
alu_out  input  8  combinational ALU result
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  8  captured result
rsp_opcode  output  4  opcode that produced rsp_data
rsp_err  output  1  1 = divide by zero (opcode 0011, b==0)
busy  output  1  FSM not IDLE or FIFO non-empty
op_count  output  CNT_W  completed responses, saturating

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; FIFO empty; alu_a/alu_b/alu_opcode/rsp_data/rsp_opcode=0; rsp_valid/rsp_err/busy=0; op_count=0. cmd_ready=1 once reset is released.
- Push: on cmd_valid & cmd_ready, write {a,b,opcode} at the tail. cmd_ready depends only on the FIFO count; no push when full; no bypass when empty.
- FSM states: IDLE, DRIVE, PRESENT.
- IDLE: if the FIFO is non-empty, pop the head into alu_a/alu_b/alu_opcode and go to DRIVE.
- DRIVE: one cycle for ALU settle. At the end of the cycle, capture:
  - rsp_data = alu_out, or 8'hFF when opcode==0011 and alu_b==0.
  - rsp_opcode = alu_opcode.
  - rsp_err = (opcode==0011 and alu_b==0).
  - Then go to PRESENT.
- PRESENT: rsp_valid=1. rsp_data, rsp_opcode and rsp_err stay stable until the handshake.
  - On rsp_ready with FIFO non-empty: pop the next command into the ALU regs, go to DRIVE.
  - On rsp_ready with FIFO empty: go to IDLE.
  - Without rsp_ready: stay.
- Latency: command accepted at edge k into an empty, idle unit gives rsp_valid high from edge k+2. Sustained throughput is 1 response per 2 cycles.
- Simultaneous push and pop in the same cycle are both honoured; the count is unchanged.
- Read and write pointers wrap modulo DEPTH.
- alu_a/alu_b/alu_opcode hold the last issued command until the next pop; they are not cleared in IDLE.
- Arithmetic: rsp_data is the low 8 bits of the ALU result. Overflow is not flagged; only divide-by-zero sets rsp_err.
- op_count increments on each rsp_valid & rsp_ready and saturates at all-ones.
- busy = (state!=IDLE) | !fifo_empty.
- Capacity: up to DEPTH commands queued plus one in flight, so DEPTH+1 accepted before cmd_ready drops while rsp_ready=0.
- Reset asserted mid-operation: all state is cleared immediately. In-flight and queued commands are discarded with no response.

Test Plan:
- Add: a=200, b=100, op=0000, rsp_ready=1 -> rsp_valid 2 cycles after acceptance; rsp_data=44, rsp_err=0, rsp_opcode=0000, op_count=1.
- Multiply and divide: {a=16,b=20,op=0010}, then {a=100,b=7,op=0011} -> rsp_data=64, then 14; responses in order, 2 cycles apart.
- Divide by zero: a=55, b=0, op=0011 -> rsp_data=8'hFF, rsp_err=1. A following {a=9,b=1,op=1111} -> rsp_data=2, rsp_err=0.
- Backpressure with DEPTH=4: rsp_ready=0, stream 6 commands -> exactly 5 accepted, cmd_ready=0. rsp_data holds its first value for the whole stall. Releasing rsp_ready drains 5 responses in order, then busy=0.
- Reset mid-stream: 3 commands queued, rsp_valid=1, pull rst_n low -> rsp_valid=0, busy=0 and alu_* =0 asynchronously. After release, no stale response appears.
- Back-to-back with rsp_ready=1: 8 commands {a=i, b=1, op=1000} -> results i+1, one per 2 cycles, op_count=8.
